// File: rtl/layer_seq.sv
// Sequential fully-connected layer: streams NUM_INPUTS samples into NN parallel
// MAC accumulators, then applies bias, fixed-point rescale, saturation and activation.
module layer_seq #(
  parameter int NN         = 4,
  parameter int NUM_INPUTS = 30,
  parameter int DATA_W     = 16,
  parameter int INT_W      = 4,
  parameter int LAYER_NUM  = 3,
  parameter int ACT_RELU   = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  weightValid,
  input  logic                                  biasValid,
  input  logic [31:0]                           weightValue,
  input  logic [31:0]                           biasValue,
  input  logic [31:0]                           config_layer_num,
  input  logic [31:0]                           config_neuron_num,
  input  logic                                  x_valid,
  output logic                                  x_ready,
  input  logic [DATA_W-1:0]                     x_in,
  output logic                                  o_valid,
  input  logic                                  o_ready,
  output logic [DATA_W-1:0]                     o_data,
  output logic [((NN > 1) ? $clog2(NN) : 1)-1:0] o_idx,
  output logic                                  o_last
);

  localparam int FRAC_W = DATA_W - INT_W;
  localparam int IDX_W  = (NN > 1) ? $clog2(NN) : 1;
  localparam int K_W    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 2 * DATA_W + $clog2(NUM_INPUTS) + 1;

  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};

  typedef enum logic [1:0] {ST_ACCUM, ST_FINISH, ST_OUT} state_t;

  state_t                   state_q, state_d;
  logic [K_W-1:0]           k_q;
  logic [IDX_W-1:0]         idx_q;
  logic signed [ACC_W-1:0]  acc_q  [NN];
  logic signed [DATA_W-1:0] res_q  [NN];
  logic signed [DATA_W-1:0] w_q    [NN][NUM_INPUTS];
  logic signed [DATA_W-1:0] bias_q [NN];
  logic [K_W-1:0]           wp_q   [NN];
  logic signed [PROD_W-1:0] prod_p0 [NN];

  logic signed [DATA_W-1:0] x_s, w_new, b_new;
  logic                     x_acc, last_in, o_hs, last_i, out_done, cfg_ok;
  logic [IDX_W-1:0]         wr_n;
  logic                     unused_hi;

  // Bias is aligned to the accumulator's binary point, then the sum is floored back to DATA_W.
  function automatic logic signed [ACC_W:0] shift_sat(input logic signed [ACC_W-1:0] acc,
                                                      input logic signed [DATA_W-1:0] b);
    logic signed [ACC_W:0] bext, s, r;
    bext = {{(ACC_W + 1 - DATA_W){b[DATA_W-1]}}, b};
    s    = {acc[ACC_W-1], acc} + (bext <<< FRAC_W);
    r    = s >>> FRAC_W;
    if (r > SAT_MAX) r = SAT_MAX;
    else if (r < SAT_MIN) r = SAT_MIN;
    return r;
  endfunction

  function automatic logic signed [DATA_W-1:0] activate(input logic signed [ACC_W:0] r);
    logic signed [ACC_W:0] a;
    a = r;
    if (ACT_RELU != 0 && a < 0) a = '0;
    return a[DATA_W-1:0];
  endfunction

  assign x_s       = x_in;
  assign w_new     = weightValue[DATA_W-1:0];
  assign b_new     = biasValue[DATA_W-1:0];
  assign unused_hi = ^{weightValue[31:DATA_W], biasValue[31:DATA_W]};

  assign x_ready  = (state_q == ST_ACCUM);
  assign o_valid  = (state_q == ST_OUT);
  assign x_acc    = x_valid && x_ready;
  assign last_in  = x_acc && (k_q == K_W'(NUM_INPUTS - 1));
  assign last_i   = o_valid && (idx_q == IDX_W'(NN - 1));
  assign o_hs     = o_valid && o_ready;
  assign out_done = o_hs && last_i;
  assign o_last   = last_i;
  assign o_idx    = idx_q;
  assign o_data   = res_q[idx_q];

  // Coefficient writes only land between frames so a running dot product never sees a mixed set.
  assign cfg_ok = (state_q == ST_ACCUM) && (k_q == '0) &&
                  (config_layer_num == 32'(LAYER_NUM)) && (config_neuron_num < 32'(NN));
  assign wr_n   = config_neuron_num[IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM:  if (last_in) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_OUT;
      ST_OUT:    if (out_done) state_d = ST_ACCUM;
      default:   state_d = ST_ACCUM;
    endcase
  end

  always_comb begin
    for (int n = 0; n < NN; n++) prod_p0[n] = PROD_W'(x_s) * PROD_W'(w_q[n][k_q]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_ACCUM;
      k_q     <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (x_acc) k_q <= last_in ? '0 : k_q + K_W'(1);
      if (o_hs)  idx_q <= last_i ? '0 : idx_q + IDX_W'(1);
    end
  end

  // p0: accumulate products; p1: registered per-neuron result for the output stream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < NN; n++) begin
        acc_q[n] <= '0;
        res_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NN; n++) begin
        if (x_acc) acc_q[n] <= acc_q[n] + ACC_W'(prod_p0[n]);
        else if (out_done) acc_q[n] <= '0;
        if (state_q == ST_FINISH) res_q[n] <= activate(shift_sat(acc_q[n], bias_q[n]));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < NN; n++) begin
        bias_q[n] <= '0;
        wp_q[n]   <= '0;
        for (int i = 0; i < NUM_INPUTS; i++) w_q[n][i] <= '0;
      end
    end else begin
      for (int n = 0; n < NN; n++) begin
        if (weightValid && cfg_ok && wr_n == IDX_W'(n)) begin
          w_q[n][wp_q[n]] <= w_new;
          wp_q[n]         <= (wp_q[n] == K_W'(NUM_INPUTS - 1)) ? '0 : wp_q[n] + K_W'(1);
        end
        if (biasValid && cfg_ok && wr_n == IDX_W'(n)) bias_q[n] <= b_new;
      end
    end
  end

endmodule
